// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin register-write arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_MAX_HOLD = 4;
   localparam int HOLD_W       = 4;

   function automatic int wrap_inc(input int idx, input int n);
      if (idx + 1 >= n) begin
         return 0;
      end else begin
         return idx + 1;
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requesting index at or after rr_ptr, wrapping.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] rr_ptr,
   output logic                     found,
   output logic [$clog2(N_REQ)-1:0] idx
);

   localparam int PW = $clog2(N_REQ);

   // Scan from farthest to nearest offset so the nearest requester wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         int cand;
         cand = (int'(rr_ptr) + i) % N_REQ;
         if (req[cand]) begin
            found = 1'b1;
            idx   = PW'(cand);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter granting N_REQ writers access to one shared register,
// with a per-tenure hold limit and back-to-back hand-over on release.
module reg_wr_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic [$clog2(N_REQ)-1:0]  owner,
   output logic [DATA_W-1:0]         q,
   output logic                      q_valid
);

   localparam int PW = $clog2(N_REQ);

   arb_state_e        state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [PW-1:0]     owner_q, owner_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   logic [PW-1:0]     next_ptr_s, pick_ptr_s, pick_idx_s;
   logic              pick_found_s, release_s;
   logic [DATA_W-1:0] owner_wdata_s;

   assign next_ptr_s = PW'(wrap_inc(int'(owner_q), N_REQ));
   assign release_s  = (state_q == GRANT) &&
                       (!req[owner_q] || (hold_q == HOLD_W'(MAX_HOLD - 1)));
   // On release the next winner is searched from the post-release pointer.
   assign pick_ptr_s = (state_q == GRANT) ? next_ptr_s : rr_ptr_q;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (req),
      .rr_ptr (pick_ptr_s),
      .found  (pick_found_s),
      .idx    (pick_idx_s)
   );

   // Select the current owner's write data slice.
   always_comb begin
      owner_wdata_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (owner_q == PW'(k)) begin
            owner_wdata_s = wdata[k*DATA_W +: DATA_W];
         end else begin
            owner_wdata_s = owner_wdata_s;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_found_s) state_d = GRANT;
            else              state_d = IDLE;
         end
         GRANT: begin
            if (release_s && !pick_found_s) state_d = IDLE;
            else                            state_d = GRANT;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and datapath next values.
   always_comb begin
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      hold_d   = hold_q;
      data_d   = data_q;
      valid_d  = valid_q;
      case (state_q)
         IDLE: begin
            if (pick_found_s) begin
               owner_d             = pick_idx_s;
               hold_d              = '0;
               gnt_d               = '0;
               gnt_d[pick_idx_s]   = 1'b1;
            end else begin
               gnt_d = '0;
            end
         end
         GRANT: begin
            if (req[owner_q]) begin
               data_d  = owner_wdata_s;
               valid_d = 1'b1;
            end else begin
               data_d  = data_q;
            end
            if (release_s) begin
               rr_ptr_d = next_ptr_s;
               hold_d   = '0;
               gnt_d    = '0;
               if (pick_found_s) begin
                  owner_d           = pick_idx_s;
                  gnt_d[pick_idx_s] = 1'b1;
               end else begin
                  owner_d = owner_q;
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   // Grant, pointer, hold counter and shared register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q    <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         hold_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         hold_q   <= hold_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign gnt     = gnt_q;
   assign owner   = owner_q;
   assign q       = data_q;
   assign q_valid = valid_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Randomized scoreboard bench for reg_wr_arbiter with a behavioural reference model.
module tb_reg_wr_arbiter;

   localparam int N        = 4;
   localparam int DW       = 8;
   localparam int MAX_HOLD = 4;
   localparam int BOUND    = (N - 1) * MAX_HOLD + 1;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]  gnt;
   logic [1:0]    owner;
   logic [DW-1:0] q;
   logic          q_valid;

   reg_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .wdata   (wdata),
      .gnt     (gnt),
      .owner   (owner),
      .q       (q),
      .q_valid (q_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  gnt;
      logic [1:0]    owner;
      logic [DW-1:0] q;
      logic          qv;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: owner is -1 while nobody holds the register.
   int            m_owner;
   int            m_hold;
   int            m_ptr;
   logic [DW-1:0] m_q;
   logic          m_qv;
   int            rst_epoch = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_hold  = 0;
      m_ptr   = 0;
      m_q     = '0;
      m_qv    = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic model_step();
      int   k;
      exp_t e;
      if (m_owner < 0) begin
         m_owner = pick(req, m_ptr);
         m_hold  = 0;
      end else begin
         k = m_owner;
         if (req[k]) begin
            m_q  = wdata[k*DW +: DW];
            m_qv = 1'b1;
         end
         if (!req[k] || m_hold == MAX_HOLD - 1) begin
            m_ptr   = (k + 1) % N;
            m_owner = pick(req, m_ptr);
            m_hold  = 0;
         end else begin
            m_hold++;
         end
      end
      e.gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      e.owner = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      e.q     = m_q;
      e.qv    = m_qv;
      sb_q.push_back(e);
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic [N*DW-1:0] w);
      @(posedge clk);
      #2;
      req   = r;
      wdata = w;
      model_step();
   endtask

   task automatic pulse_reset(input logic [N-1:0] r, input logic [N*DW-1:0] w);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_q", 32'(q), 32'h0);
      check("rst_qvalid", 32'(q_valid), 32'h0);
      sb_q.delete();
      model_reset();
      rst_epoch++;
      #1;
      rst_n = 1'b1;
      req   = r;
      wdata = w;
      model_step();
   endtask

   // Monitor: compare DUT outputs just after each edge against the scoreboard.
   exp_t e_m;
   int   wait_cnt [N];
   int   seen_epoch = 0;
   always @(posedge clk) begin
      #1;
      if (seen_epoch != rst_epoch) begin
         seen_epoch = rst_epoch;
         for (int k = 0; k < N; k++) wait_cnt[k] = 0;
      end
      if (rst_n && sb_q.size() > 0) begin
         e_m = sb_q.pop_front();
         check("gnt", 32'(gnt), 32'(e_m.gnt));
         check("q", 32'(q), 32'(e_m.q));
         check("q_valid", 32'(q_valid), 32'(e_m.qv));
         if (e_m.gnt != 4'b0000) check("owner", 32'(owner), 32'(e_m.owner));
         check("gnt_onehot0", 32'($onehot0(gnt)), 32'h1);
      end
      if (rst_n) begin
         for (int k = 0; k < N; k++) begin
            if (gnt[k] && wait_cnt[k] > 0) check("starvation", 32'(wait_cnt[k] <= BOUND), 32'h1);
            if (req[k] && !gnt[k]) wait_cnt[k]++;
            else wait_cnt[k] = 0;
            if (wait_cnt[k] == BOUND + 1) check("starvation_limit", 32'(wait_cnt[k]), 32'(BOUND));
         end
      end
   end

   logic [N*DW-1:0] w_s;
   logic [N-1:0]    r_s;

   initial begin
      rst_n = 1'b0;
      req   = '0;
      wdata = '0;
      model_reset();
      #3;
      check("init_gnt", 32'(gnt), 32'h0);
      check("init_owner", 32'(owner), 32'h0);
      check("init_q", 32'(q), 32'h0);
      check("init_qvalid", 32'(q_valid), 32'h0);
      #9;
      rst_n = 1'b1;

      // Single requester 2, three cycles of data then drop.
      for (int i = 0; i < 3; i++) cycle(4'b0100, 32'h00A5_0000);
      for (int i = 0; i < 3; i++) cycle(4'b0000, 32'h0);

      // All four requesting: full-length tenures back to back.
      for (int i = 0; i < 22; i++) cycle(4'b1111, 32'h1312_1110);
      for (int i = 0; i < 2; i++) cycle(4'b0000, 32'h0);

      // Lone requester 1 re-granted at the hold limit without a gap.
      for (int i = 0; i < 10; i++) cycle(4'b0010, 32'($urandom));
      cycle(4'b0000, 32'h0);

      // Owner 3 with requester 0 pending, then 3 drops.
      cycle(4'b1000, 32'h7700_0000);
      cycle(4'b1001, 32'h7800_0001);
      cycle(4'b0001, 32'h0000_0002);
      cycle(4'b0001, 32'h0000_0003);

      // Reset mid-tenure after q has taken 0x3C.
      for (int i = 0; i < 2; i++) cycle(4'b0100, 32'h003C_0000);
      pulse_reset(4'b1111, 32'h4342_4140);
      for (int i = 0; i < 6; i++) cycle(4'b1111, 32'h4342_4140);

      // Random traffic: requests only drop while granted.
      for (int c = 0; c < 10000; c++) begin
         r_s = req;
         for (int k = 0; k < N; k++) begin
            if (!r_s[k]) begin
               if ($urandom_range(3, 0) == 0) r_s[k] = 1'b1;
            end else if (m_owner == k) begin
               if ($urandom_range(2, 0) == 0) r_s[k] = 1'b0;
            end
         end
         w_s = 32'($urandom);
         cycle(r_s, w_s);
      end

      cycle(4'b0000, 32'h0);
      repeat (2) @(posedge clk);
      #3;
      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: DATA_W, 8, width of the shared register.
REQ-003 Parameter: MAX_HOLD, 4, maximum consecutive grant cycles per tenure (1..15).
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: req  in  N_REQ  per-requester write request, level, held until served.
REQ-007 Port: wdata  in  N_REQ*DATA_W  per-requester write data; slice k is [k*DATA_W +: DATA_W].
REQ-008 Port: gnt  out  N_REQ  registered one-hot grant (all-zero when idle).
REQ-009 Port: owner  out  $clog2(N_REQ)  index of current grantee; valid while any gnt bit is high.
REQ-010 Port: q  out  DATA_W  shared register contents.
REQ-011 Port: q_valid  out  1  high once q has been written since reset.

Function
REQ-012 FSM SHALL have two states: IDLE (gnt=0) and GRANT (exactly one gnt bit high).
REQ-013 IDLE with any req high at an edge -> GRANT; gnt/owner show winner from the following cycle.
REQ-014 Winner SHALL be the first requesting index at or after rr_ptr, wrapping N_REQ-1 -> 0.
REQ-015 Write: at each edge where gnt[k] & req[k], q <= wdata[k] and q_valid <= 1; no other condition writes q.
REQ-016 hold_cnt SHALL reset to 0 on each new grant and increment on each grant edge.
REQ-017 Release: at an edge with gnt[k] and (!req[k] or hold_cnt==MAX_HOLD-1); rr_ptr <= (k+1) mod N_REQ.
REQ-018 On release, if any req high (evaluated with the new rr_ptr), grant the next winner at the same edge, no idle bubble; else -> IDLE.
REQ-019 A requester released by the hold limit and still the only requester SHALL be re-granted immediately, with hold_cnt restarted.
REQ-020 req rising while another tenure is active SHALL wait; req dropping without a grant SHALL have no effect.
REQ-021 gnt SHALL never have more than one bit high; owner SHALL equal the index of the high bit.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, gnt=0, owner=0, q=0, q_valid=0, rr_ptr=0, hold_cnt=0, including mid-tenure.
REQ-023 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge with rst_n high.

Structure
REQ-024 Package arb_pkg SHALL hold the state enum (IDLE, GRANT) and default values for N_REQ, DATA_W and MAX_HOLD.
REQ-025 Combinational round-robin selector SHALL be a sub-module rr_pick (inputs req and rr_ptr; outputs found and idx).
REQ-026 The storage register, hold counter and FSM SHALL reside in reg_wr_arbiter.

Verification (N_REQ=4, DATA_W=8, MAX_HOLD=4)
REQ-027 req[2]=1, wdata[2]=0xA5 for 3 cycles then 0 -> gnt=0100 from cycle 2; q=0xA5, q_valid=1 after first grant edge; IDLE after release.
REQ-028 req=1111 from reset, data k=0x10+k -> tenures 0,1,2,3,0 of 4 cycles each, back-to-back; q follows the owner's data.
REQ-029 Only req[1] held for 10 cycles -> gnt=0010 continuously; hold_cnt wraps 0..3; no zero-gnt cycle.
REQ-030 Owner 3 active, req[0] pending, req[3] drops -> gnt=0001 at the same edge; rr_ptr=0.
REQ-031 rst_n pulsed low mid-tenure (q=0x3C) -> gnt=0, q=0x00, q_valid=0 before the next edge; arbitration restarts from index 0.
REQ-032 Random req/wdata for 10k cycles with checks: gnt one-hot or zero; q changes only on grant & req; no starvation beyond (N_REQ-1)*MAX_HOLD+1 cycles.
